tdm_clk_gen: RTL
================

// Module: tdm_clk_gen
// PURPOSE
//  Synthesizable, parametrised generator of gated per-channel TDM bit clocks (clk_o) and enable windows (clk_en).
//  Driven by one fast system clock; timing unit is the quarter bit period Q = QTR_DIV clk cycles (122 ns at 2.048 Mb/s).
//  Frame start = falling edge of f0_n_i; burst start = falling edge of c4_i. Each channel has its own delay, pulse count and tail-pulse mode.
//  Sits between the frame-sync input pins and the per-channel serial shifters.
// PARAMETERS
//  N_CH        4   number of channels
//  QTR_DIV     8   clk cycles per quarter bit period Q (>=2)
//  CNT_W       6   width of per-channel pulse count
//  DLY_W       4   width of per-channel start delay, in Q units
//  SYNC_STAGES 2   synchroniser depth on f0_n_i and c4_i (>=2)
// PORTS
//  clk         in   1            system clock
//  rst         in   1            synchronous reset, active high
//  f0_n_i      in   1            frame sync, asynchronous, active low
//  c4_i        in   1            burst-start reference, asynchronous
//  cfg_delay   in   N_CH*DLY_W   per-channel delay from c4 edge to first rise, in Q
//  cfg_pulses  in   N_CH*CNT_W   per-channel pulses inside enable window (0 allowed)
//  cfg_tail    in   N_CH         1 = emit one extra pulse after clk_en drops
//  clk_en      out  N_CH         per-channel enable window
//  clk_o       out  N_CH         per-channel gated bit clock
//  busy        out  1            OR of all channels not IDLE
//  frame_err   out  1            1-cycle pulse: f0 edge while any channel beyond ARMED
// BEHAVIOUR
//  - Reset: clk_en=0, clk_o=0, busy=0, frame_err=0, all channels IDLE, sync flops cleared to inactive (f0=1, c4=1).
//  - Inputs pass SYNC_STAGES flops, then a registered falling-edge detect -> 1-cycle strobes f0_stb, c4_stb.
//  - Per-channel FSM: IDLE, ARMED, DELAY, HI, LO, EN_HOLD, TAIL_WAIT, TAIL_HI. One Q tick counter per channel, reloaded on each state entry.
//  - f0_stb (any state): cfg for that channel latched; state=ARMED; clk_en=1 next cycle; clk_o=0. Mid-burst f0 aborts and re-arms; frame_err pulses.
//  - ARMED + c4_stb: enter DELAY for cfg_delay*Q cycles; delay 0 -> HI directly. clk_o rises cycle after c4_stb + cfg_delay*Q.
//  - HI 2Q (clk_o=1) -> LO 2Q (clk_o=0); repeated cfg_pulses times. After the last LO -> EN_HOLD 1Q, then clk_en=0.
//  - cfg_pulses=0: ARMED + c4_stb -> DELAY -> EN_HOLD; no rising edge on clk_o.
//  - cfg_tail=1: after clk_en falls, TAIL_WAIT 1Q, TAIL_HI 2Q (clk_o=1), then IDLE, clk_o=0. cfg_tail=0: EN_HOLD -> IDLE.
//  - c4_stb outside ARMED ignored. f0_stb and c4_stb in same cycle: f0 wins, c4 ignored (channel ARMED only).
//  - Pulse counter counts down from latched cfg_pulses, width CNT_W; no wrap (stops at 0). Config changes mid-frame have no effect until next f0_stb.
//  - Outputs are registered (glitch-free); clk_o is only ever high while clk_en=1, except in TAIL_HI.
//  - rst mid-operation: all outputs 0 next cycle, channels IDLE, pending strobes discarded.
// STRUCTURE
//  - Package tdm_pkg: chan_state_e enum (8 states), HI_Q=2, LO_Q=2, HOLD_Q=1, TAILW_Q=1, TAILH_Q=2.
//  - Top: synchronisers, edge detect, busy OR-reduce, frame_err logic, generate loop of N_CH instances.
//  - Sub-module tdm_chan_seq: one channel FSM, Q tick counter, pulse counter, registered clk_en/clk_o.
// TESTING
//  - QTR_DIV=4, ch0 delay0/32 pulses/no tail: f0 fall then c4 fall -> 32 pulses hi 8/lo 8 cycles, clk_en falls 4 cycles after last LO.
//  - ch1 delay3/31 pulses/tail: first rise 12 cycles after c4_stb; 31 pulses in window, clk_en falls, 4 cycles low, 8-cycle tail pulse.
//  - f0 fall during pulse 10 of ch0 -> frame_err 1 cycle, clk_o=0 next cycle, clk_en stays 1, restart on next c4 fall.
//  - c4 fall with no prior f0 -> no activity, busy=0; f0 and c4 strobes same cycle -> ARMED only, no pulses until next c4.
//  - cfg_pulses=0, delay 2 -> clk_en high until 12 cycles after c4_stb, clk_o never rises.
//  - rst asserted in TAIL_HI -> clk_o=0, clk_en=0, busy=0 on the following cycle.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and timing constants for the TDM clock generator.
// Durations are expressed in quarter-bit (Q) units.
package tdm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    DELAY     = 3'd2,
    HI        = 3'd3,
    LO        = 3'd4,
    EN_HOLD   = 3'd5,
    TAIL_WAIT = 3'd6,
    TAIL_HI   = 3'd7
  } chan_state_e;

  localparam int HI_Q    = 2;
  localparam int LO_Q    = 2;
  localparam int HOLD_Q  = 1;
  localparam int TAILW_Q = 1;
  localparam int TAILH_Q = 2;

endpackage

// File: rtl/tdm_clk_gen_if.sv
// Pin-level bundle of the TDM clock generator: frame/burst sync inputs,
// per-channel configuration and the gated clock/enable outputs.
interface tdm_clk_gen_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 6,
  parameter int DLY_W = 4
);
  logic                    f0_n_i;
  logic                    c4_i;
  logic [N_CH*DLY_W-1:0]   cfg_delay;
  logic [N_CH*CNT_W-1:0]   cfg_pulses;
  logic [N_CH-1:0]         cfg_tail;
  logic [N_CH-1:0]         clk_en;
  logic [N_CH-1:0]         clk_o;
  logic                    busy;
  logic                    frame_err;

  modport master (
    output f0_n_i, c4_i, cfg_delay, cfg_pulses, cfg_tail,
    input  clk_en, clk_o, busy, frame_err
  );

  modport slave (
    input  f0_n_i, c4_i, cfg_delay, cfg_pulses, cfg_tail,
    output clk_en, clk_o, busy, frame_err
  );
endinterface

// File: rtl/tdm_chan_seq.sv
// One TDM channel: sequences delay, clock pulses, enable hold and optional
// tail pulse in Q ticks; clk_en/clk_o are registered from the next state.
module tdm_chan_seq
  import tdm_pkg::*;
#(
  parameter int QTR_DIV = 8,
  parameter int CNT_W   = 6,
  parameter int DLY_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f0_stb_i,
  input  logic             c4_stb_i,
  input  logic [DLY_W-1:0] cfg_delay_i,
  input  logic [CNT_W-1:0] cfg_pulses_i,
  input  logic             cfg_tail_i,
  output logic             clk_en_o,
  output logic             clk_o_o,
  output logic             busy_d_o,
  output logic             active_o
);

  // Tick counter must hold the longest delay (all-ones delay times Q).
  localparam int TICK_W = $clog2((2 ** DLY_W) * QTR_DIV);

  localparam logic [TICK_W-1:0] HI_RELOAD    = TICK_W'(HI_Q * QTR_DIV - 1);
  localparam logic [TICK_W-1:0] LO_RELOAD    = TICK_W'(LO_Q * QTR_DIV - 1);
  localparam logic [TICK_W-1:0] HOLD_RELOAD  = TICK_W'(HOLD_Q * QTR_DIV - 1);
  localparam logic [TICK_W-1:0] TAILW_RELOAD = TICK_W'(TAILW_Q * QTR_DIV - 1);
  localparam logic [TICK_W-1:0] TAILH_RELOAD = TICK_W'(TAILH_Q * QTR_DIV - 1);

  chan_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0]  pulse_q, pulse_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              tail_q, tail_d;
  logic              clk_en_q, clk_en_d;
  logic              clk_o_q, clk_o_d;
  logic              tick_done_s;
  logic              go_pulse_s;

  assign tick_done_s = (tick_q == '0);

  // State, counters, latched config and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      pulse_q  <= '0;
      dly_q    <= '0;
      tail_q   <= 1'b0;
      clk_en_q <= 1'b0;
      clk_o_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      pulse_q  <= pulse_d;
      dly_q    <= dly_d;
      tail_q   <= tail_d;
      clk_en_q <= clk_en_d;
      clk_o_q  <= clk_o_d;
    end
  end

  // Next-state and counter update; a frame strobe overrides everything
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    pulse_d    = pulse_q;
    dly_d      = dly_q;
    tail_d     = tail_q;
    go_pulse_s = 1'b0;
    if (f0_stb_i) begin
      state_d = ARMED;
      tick_d  = '0;
      pulse_d = cfg_pulses_i;
      dly_d   = cfg_delay_i;
      tail_d  = cfg_tail_i;
    end else begin
      if (!tick_done_s) begin
        tick_d = tick_q - 1'b1;
      end else begin
        tick_d = tick_q;
      end
      case (state_q)
        IDLE: state_d = IDLE;
        ARMED: begin
          if (c4_stb_i && (dly_q != '0)) begin
            state_d = DELAY;
            tick_d  = TICK_W'(int'(dly_q) * QTR_DIV - 1);
          end else if (c4_stb_i) begin
            go_pulse_s = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end
        DELAY: go_pulse_s = tick_done_s;
        HI: begin
          if (tick_done_s) begin
            state_d = LO;
            tick_d  = LO_RELOAD;
          end else begin
            state_d = HI;
          end
        end
        LO: go_pulse_s = tick_done_s;
        EN_HOLD: begin
          if (tick_done_s && tail_q) begin
            state_d = TAIL_WAIT;
            tick_d  = TAILW_RELOAD;
          end else if (tick_done_s) begin
            state_d = IDLE;
          end else begin
            state_d = EN_HOLD;
          end
        end
        TAIL_WAIT: begin
          if (tick_done_s) begin
            state_d = TAIL_HI;
            tick_d  = TAILH_RELOAD;
          end else begin
            state_d = TAIL_WAIT;
          end
        end
        TAIL_HI: begin
          if (tick_done_s) begin
            state_d = IDLE;
          end else begin
            state_d = TAIL_HI;
          end
        end
        default: state_d = IDLE;
      endcase
      // Start another pulse while the counter is non-zero, else close the window
      if (go_pulse_s && (pulse_q != '0)) begin
        state_d = HI;
        tick_d  = HI_RELOAD;
        pulse_d = pulse_q - 1'b1;
      end else if (go_pulse_s) begin
        state_d = EN_HOLD;
        tick_d  = HOLD_RELOAD;
      end else begin
        pulse_d = pulse_q;
      end
    end
  end

  // Output decode from the next state so the flops line up with the state
  always_comb begin
    clk_en_d = (state_d inside {ARMED, DELAY, HI, LO, EN_HOLD});
    clk_o_d  = (state_d inside {HI, TAIL_HI});
  end

  assign clk_en_o = clk_en_q;
  assign clk_o_o  = clk_o_q;
  assign busy_d_o = (state_d != IDLE);
  assign active_o = !(state_q inside {IDLE, ARMED});

endmodule

// File: rtl/tdm_clk_gen.sv
// TDM clock generator top: synchronises frame/burst inputs, derives strobes
// and drives N_CH channel sequencers; busy and frame_err are registered.
module tdm_clk_gen #(
  parameter int N_CH        = 4,
  parameter int QTR_DIV     = 8,
  parameter int CNT_W       = 6,
  parameter int DLY_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  tdm_clk_gen_if.slave bus
);

  logic [SYNC_STAGES-1:0] f0_sync_q;
  logic [SYNC_STAGES-1:0] c4_sync_q;
  logic                   f0_prev_q, c4_prev_q;
  logic                   f0_stb_q, c4_stb_q;
  logic                   busy_q, frame_err_q;
  logic [N_CH-1:0]        clk_en_s, clk_o_s, busy_d_s, active_s;

  // Synchronisers and falling-edge strobes; idle level of both pins is high
  always_ff @(posedge clk) begin
    if (rst) begin
      f0_sync_q <= '1;
      c4_sync_q <= '1;
      f0_prev_q <= 1'b1;
      c4_prev_q <= 1'b1;
      f0_stb_q  <= 1'b0;
      c4_stb_q  <= 1'b0;
    end else begin
      f0_sync_q <= {f0_sync_q[SYNC_STAGES-2:0], bus.f0_n_i};
      c4_sync_q <= {c4_sync_q[SYNC_STAGES-2:0], bus.c4_i};
      f0_prev_q <= f0_sync_q[SYNC_STAGES-1];
      c4_prev_q <= c4_sync_q[SYNC_STAGES-1];
      f0_stb_q  <= f0_prev_q & ~f0_sync_q[SYNC_STAGES-1];
      c4_stb_q  <= c4_prev_q & ~c4_sync_q[SYNC_STAGES-1];
    end
  end

  // Status flags; busy follows the channels' next state to stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      busy_q      <= |busy_d_s;
      frame_err_q <= f0_stb_q & (|active_s);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    tdm_chan_seq #(
      .QTR_DIV (QTR_DIV),
      .CNT_W   (CNT_W),
      .DLY_W   (DLY_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .f0_stb_i     (f0_stb_q),
      .c4_stb_i     (c4_stb_q),
      .cfg_delay_i  (bus.cfg_delay[g*DLY_W +: DLY_W]),
      .cfg_pulses_i (bus.cfg_pulses[g*CNT_W +: CNT_W]),
      .cfg_tail_i   (bus.cfg_tail[g]),
      .clk_en_o     (clk_en_s[g]),
      .clk_o_o      (clk_o_s[g]),
      .busy_d_o     (busy_d_s[g]),
      .active_o     (active_s[g])
    );
  end

  assign bus.clk_en    = clk_en_s;
  assign bus.clk_o     = clk_o_s;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

endmodule
